wxbar_elastic: RTL and testbench

//  Parametrised write crossbar stage for the scratchpad write path. Routes NUM_COLS lane elements to

---
 rtl/wxbar_elastic.sv | 136 +++++++++++++
 tb/tb_wxbar_elastic.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wxbar_elastic.sv
// Write crossbar: routes lane elements to scratchpad columns by per-lane index, flags conflicts/range errors.
// LATENCY-stage elastic valid/ready pipeline; combinational ready chain gives 1 beat/cycle and collapses bubbles.
module wxbar_elastic #(
  parameter int NUM_COLS = 32,
  parameter int DWIDTH   = 16,
  parameter int LATENCY  = 2,
  parameter int SRC_W    = 2,
  parameter int SLOT_W   = 32,
  parameter int IDX_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SRC_W-1:0]                  in_src,
  input  logic [SLOT_W-1:0]                 in_slot_mask,
  input  logic [NUM_COLS-1:0]               in_valid_mask,
  input  logic [NUM_COLS*IDX_W-1:0]         in_shift,
  input  logic [NUM_COLS*DWIDTH-1:0]        in_wdata,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [SRC_W-1:0]                  out_src,
  output logic [SLOT_W-1:0]                 out_slot_mask,
  output logic [NUM_COLS-1:0]               out_col_mask,
  output logic [NUM_COLS*DWIDTH-1:0]        out_wdata,
  output logic                              out_conflict,
  output logic                              out_range_err,
  output logic [$clog2(LATENCY+1)-1:0]      occupancy
);

  localparam int OCC_W = $clog2(LATENCY + 1);

  typedef struct packed {
    logic [SRC_W-1:0]           src;
    logic [SLOT_W-1:0]          slot_mask;
    logic [NUM_COLS-1:0]        col_mask;
    logic [NUM_COLS*DWIDTH-1:0] wdata;
    logic                       conflict;
    logic                       range_err;
  } beat_t;

  beat_t              routed;
  logic [IDX_W-1:0]   dst;
  beat_t              stg_q [1:LATENCY];
  beat_t              src_beat [1:LATENCY];
  logic [LATENCY:1]   vld_q, vld_d;
  logic [LATENCY:1]   rdy;
  logic [LATENCY:1]   ld;
  logic [LATENCY:0]   chain_vld;
  logic               chain;
  logic               acc_en, deq_en;
  logic [OCC_W-1:0]   occ_q, occ_d;

  // Lanes are scanned in ascending order so the lowest lane claims a column first.
  always_comb begin
    routed           = '0;
    routed.src       = in_src;
    routed.slot_mask = in_slot_mask;
    dst              = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      dst = in_shift[i*IDX_W +: IDX_W];
      if (in_valid_mask[i]) begin
        if (int'(dst) >= NUM_COLS) begin
          routed.range_err = 1'b1;
        end else if (routed.col_mask[dst]) begin
          routed.conflict = 1'b1;
        end else begin
          routed.col_mask[dst]                  = 1'b1;
          routed.wdata[dst*DWIDTH +: DWIDTH]    = in_wdata[i*DWIDTH +: DWIDTH];
        end
      end
    end
  end

  // Stage k can take a beat if it, or any stage after it, has a hole, or the output drains.
  always_comb begin
    rdy   = '0;
    chain = out_ready;
    for (int k = LATENCY; k >= 1; k--) begin
      chain  = chain | ~vld_q[k];
      rdy[k] = chain;
    end
  end

  assign in_ready  = !flush && rdy[1];
  assign acc_en    = in_valid && in_ready;
  assign deq_en    = vld_q[LATENCY] && out_ready;
  assign chain_vld = {vld_q, acc_en};

  always_comb begin
    src_beat[1] = routed;
    for (int k = 2; k <= LATENCY; k++) src_beat[k] = stg_q[k-1];
  end

  always_comb begin
    vld_d = vld_q;
    ld    = '0;
    for (int k = 1; k <= LATENCY; k++) begin
      ld[k] = !flush && rdy[k] && chain_vld[k-1];
      if (rdy[k]) vld_d[k] = chain_vld[k-1];
    end
    if (flush) vld_d = '0;
  end

  always_comb begin
    occ_d = occ_q;
    if (flush)                occ_d = '0;
    else if (acc_en && !deq_en) occ_d = occ_q + 1'b1;
    else if (!acc_en && deq_en) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int k = 1; k <= LATENCY; k++) stg_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      for (int k = 1; k <= LATENCY; k++) begin
        if (ld[k]) stg_q[k] <= src_beat[k];
      end
    end
  end

  assign out_valid     = vld_q[LATENCY];
  assign out_src       = stg_q[LATENCY].src;
  assign out_slot_mask = stg_q[LATENCY].slot_mask;
  assign out_col_mask  = stg_q[LATENCY].col_mask;
  assign out_wdata     = stg_q[LATENCY].wdata;
  assign out_conflict  = stg_q[LATENCY].conflict;
  assign out_range_err = stg_q[LATENCY].range_err;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_wxbar_elastic.sv
// Bench for wxbar_elastic (4 cols, 8-bit, 2 stages): directed cases plus randomized traffic vs a column-view model.
module tb_wxbar_elastic;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam int LAT = 2;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_src, out_src;
  logic [31:0] in_slot_mask, out_slot_mask;
  logic [3:0]  in_valid_mask, out_col_mask;
  logic [7:0]  in_shift;
  logic [31:0] in_wdata, out_wdata;
  logic        out_conflict, out_range_err;
  logic [1:0]  occupancy;

  wxbar_elastic #(.NUM_COLS(NC), .DWIDTH(DW), .LATENCY(LAT), .SRC_W(2), .SLOT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_slot_mask(in_slot_mask), .in_valid_mask(in_valid_mask),
    .in_shift(in_shift), .in_wdata(in_wdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_slot_mask(out_slot_mask), .out_col_mask(out_col_mask),
    .out_wdata(out_wdata), .out_conflict(out_conflict), .out_range_err(out_range_err),
    .occupancy(occupancy)
  );

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] slot;
    logic [3:0]  colmask;
    logic [31:0] wdata;
    logic        conflict;
    logic        rerr;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Each column independently looks for the lowest valid lane pointing at it.
  function automatic exp_t model(input logic [1:0] src, input logic [31:0] slot,
                                 input logic [3:0] m, input logic [7:0] sh, input logic [31:0] wd);
    exp_t e;
    int   cnt;
    e      = '0;
    e.src  = src;
    e.slot = slot;
    for (int c = 0; c < NC; c++) begin
      cnt = 0;
      for (int i = 0; i < NC; i++) begin
        if (m[i] && int'(sh[i*2 +: 2]) == c) begin
          if (cnt == 0) e.wdata[c*DW +: DW] = wd[i*DW +: DW];
          cnt++;
        end
      end
      if (cnt > 0) e.colmask[c] = 1'b1;
      if (cnt > 1) e.conflict   = 1'b1;
    end
    for (int i = 0; i < NC; i++)
      if (m[i] && int'(sh[i*2 +: 2]) >= NC) e.rerr = 1'b1;
    return e;
  endfunction

  always @(posedge rst) q.delete();

  always @(negedge clk) begin : sb
    exp_t e, a;
    if (rst) begin
      q.delete();
    end else begin
      chk("occupancy", occupancy, q.size());
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          a = {out_src, out_slot_mask, out_col_mask, out_wdata, out_conflict, out_range_err};
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_unexpected: got beat %0h want none", a);
          end else begin
            e = q.pop_front();
            chk("out_beat", a, e);
          end
        end
        if (in_valid && in_ready)
          q.push_back(model(in_src, in_slot_mask, in_valid_mask, in_shift, in_wdata));
      end
    end
  end

  task automatic put(input logic v, input logic [1:0] s, input logic [31:0] sl,
                     input logic [3:0] m, input logic [7:0] sh, input logic [31:0] wd);
    in_valid = v; in_src = s; in_slot_mask = sl; in_valid_mask = m; in_shift = sh; in_wdata = wd;
  endtask

  task automatic idle();
    put(1'b0, 2'd0, 32'd0, 4'd0, 8'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  bsrc [5];
  logic [31:0] bslot [5];
  logic [3:0]  bm [5];
  logic [7:0]  bsh [5];
  logic [31:0] bwd [5];

  initial begin
    int idx, acc_cnt, cyc;
    logic accepted;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_occupancy", occupancy, 2'd0);
    chk("reset_wdata", out_wdata, 32'd0);
    step();
    rst = 1'b0;

    // async reset with two beats in flight
    put(1'b1, 2'd1, 32'h11, 4'hF, 8'h1B, 32'h01020304); step();
    put(1'b1, 2'd2, 32'h22, 4'hF, 8'hE4, 32'h05060708); step();
    idle();
    @(negedge clk);
    chk("rst_pre_occ", occupancy, 2'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_out_valid", out_valid, 1'b0);
    chk("rst_async_occ", occupancy, 2'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // rotation
    out_ready = 1'b1;
    step();
    put(1'b1, 2'd3, 32'hA5A5, 4'hF, {2'd0, 2'd3, 2'd2, 2'd1}, {8'd13, 8'd12, 8'd11, 8'd10});
    step(); idle();
    @(negedge clk);
    chk("rot_lat1", out_valid, 1'b0);
    step();
    @(negedge clk);
    chk("rot_valid", out_valid, 1'b1);
    chk("rot_wdata", out_wdata, {8'd12, 8'd11, 8'd10, 8'd13});
    chk("rot_colmask", out_col_mask, 4'hF);
    chk("rot_conflict", out_conflict, 1'b0);

    // conflict: l0,l2 -> 1, l1 -> 0, l3 invalid
    step();
    put(1'b1, 2'd0, 32'h5A, 4'b0111, {2'd2, 2'd1, 2'd0, 2'd1}, 32'hA3A2A1A0);
    step(); idle();
    step();
    @(negedge clk);
    chk("cfl_valid", out_valid, 1'b1);
    chk("cfl_wdata", out_wdata, 32'h0000A0A1);
    chk("cfl_colmask", out_col_mask, 4'b0011);
    chk("cfl_conflict", out_conflict, 1'b1);
    repeat (3) step();

    // backpressure: 5 beats against a stalled output
    for (int i = 0; i < 5; i++) begin
      bsrc[i] = 2'($urandom); bslot[i] = $urandom; bm[i] = 4'($urandom);
      bsh[i] = 8'($urandom); bwd[i] = $urandom;
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      if (idx < 5) put(1'b1, bsrc[idx], bslot[idx], bm[idx], bsh[idx], bwd[idx]); else idle();
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      step();
    end
    @(negedge clk);
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_occ", occupancy, 2'd2);
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (idx < 5) put(1'b1, bsrc[idx], bslot[idx], bm[idx], bsh[idx], bwd[idx]); else idle();
      @(negedge clk);
      chk("bp_stream_valid", out_valid, 1'b1);
      if (in_valid && in_ready) idx++;
      step();
    end
    idle();
    @(negedge clk);
    chk("bp_all_in", idx, 5);
    chk("bp_drained", out_valid, 1'b0);

    // flush with a full pipeline and an offered beat
    step();
    out_ready = 1'b0;
    put(1'b1, 2'd1, 32'h1, 4'h3, 8'h04, 32'h11223344); step();
    put(1'b1, 2'd2, 32'h2, 4'h5, 8'h21, 32'h55667788); step();
    put(1'b1, 2'd3, 32'h3, 4'hF, 8'hFF, 32'h99AABBCC);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1'b0);
    step();
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_occ", occupancy, 2'd0);
    step();
    out_ready = 1'b1;
    put(1'b1, 2'd2, 32'h77, 4'b1001, 8'h3C, 32'hDEADBEEF);
    step(); idle();
    @(negedge clk);
    chk("post_flush_lat1", out_valid, 1'b0);
    step();
    @(negedge clk);
    chk("post_flush_lat2", out_valid, 1'b1);
    step();

    // randomized traffic
    acc_cnt = 0; cyc = 0; accepted = 1'b0;
    while (acc_cnt < 10000 && cyc < 60000) begin
      if (!in_valid || accepted)
        put(1'($urandom_range(0, 9) < 7), 2'($urandom), $urandom, 4'($urandom),
            8'($urandom), $urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      accepted = in_valid && in_ready;
      if (accepted) acc_cnt++;
      step();
      cyc++;
    end
    chk("rand_beats", acc_cnt, 10000);
    flush = 1'b0; out_ready = 1'b1;
    idle();
    repeat (4) step();
    @(negedge clk);
    chk("rand_sb_empty", q.size(), 0);
    chk("rand_final_occ", occupancy, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
